// File: rtl/nonce_result_hub_pkg.sv
// Shared widths, result layout and busy-mode encodings for the nonce result hub.
// A FIFO entry is stored as {chan, result_t}, with chan sized to the channel index.
package nonce_result_hub_pkg;

    localparam int NONCE_W    = 40;
    localparam int DIFY_W     = 32;
    localparam int DROP_W     = 8;
    localparam int DROP_INC_W = 5;

    typedef enum logic {
        BUSY_ALL = 1'b0,
        BUSY_ANY = 1'b1
    } busy_mode_e;

    typedef struct packed {
        logic [NONCE_W-1:0] id_nonce;
        logic [DIFY_W-1:0]  hash_dify;
    } result_t;

    function automatic logic [DROP_W-1:0] sat_add_drop(
        input logic [DROP_W-1:0]     base,
        input logic [DROP_INC_W-1:0] inc
    );
        logic [DROP_W:0] sum;
        sum = {1'b0, base} + {{(DROP_W + 1 - DROP_INC_W){1'b0}}, inc};
        return sum[DROP_W] ? {DROP_W{1'b1}} : sum[DROP_W-1:0];
    endfunction

endpackage

// File: rtl/nonce_result_hub_if.sv
// Core-array and SPI-side signals of the nonce result hub.
// The hub uses the slave view; the core array / SPI driver uses the master view.
interface nonce_result_hub_if #(
    parameter int N_CORES = 4,
    parameter int DEPTH   = 8
);
    import nonce_result_hub_pkg::*;

    localparam int CW    = $clog2(N_CORES);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [N_CORES-1:0]         core_valid;
    logic [N_CORES*NONCE_W-1:0] core_id_nonce;
    logic [N_CORES*DIFY_W-1:0]  core_hash_dify;
    logic [N_CORES-1:0]         core_busy;
    logic                       busy_mode;
    logic                       pop;
    logic                       clr_overflow;
    logic                       rd_valid;
    logic [CW-1:0]              rd_chan;
    logic [NONCE_W-1:0]         rd_id_nonce;
    logic [DIFY_W-1:0]          rd_hash_dify;
    logic [CNT_W-1:0]           fifo_count;
    logic                       irq;
    logic                       busy_out;
    logic                       overflow;
    logic [DROP_W-1:0]          drop_count;

    modport master (
        output core_valid, core_id_nonce, core_hash_dify, core_busy, busy_mode,
        output pop, clr_overflow,
        input  rd_valid, rd_chan, rd_id_nonce, rd_hash_dify, fifo_count, irq,
        input  busy_out, overflow, drop_count
    );

    modport slave (
        input  core_valid, core_id_nonce, core_hash_dify, core_busy, busy_mode,
        input  pop, clr_overflow,
        output rd_valid, rd_chan, rd_id_nonce, rd_hash_dify, fifo_count, irq,
        output busy_out, overflow, drop_count
    );

endinterface

// File: rtl/nonce_result_hub_result_fifo.sv
// Synchronous first-word-fall-through FIFO; the head reads as zero while empty
// so the hub outputs are deterministic after reset.
module result_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full    = (r_count == (AW + 1)'(DEPTH));
    assign o_empty   = (r_count == {(AW + 1){1'b0}});
    assign o_count   = r_count;
    assign w_push_ok = i_push & ~o_full;
    assign w_pop_ok  = i_pop & ~o_empty;
    assign o_rdata   = o_empty ? {WIDTH{1'b0}} : r_mem[r_rptr];

    // Storage write; contents need no reset because reads are masked while empty.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    // Pointer and occupancy tracking; power-of-two depth makes pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wptr  <= {AW{1'b0}};
            r_rptr  <= {AW{1'b0}};
            r_count <= {(AW + 1){1'b0}};
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + AW'(1'b1);
            end
            if (w_pop_ok) begin
                r_rptr <= r_rptr + AW'(1'b1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + (AW + 1)'(1'b1);
                2'b01:   r_count <= r_count - (AW + 1)'(1'b1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/nonce_result_hub.sv
// Collects per-core nonce results into one-entry pending slots, arbitrates them
// round-robin into a FWFT FIFO, and reports irq, busy summary and drop statistics.
module nonce_result_hub
    import nonce_result_hub_pkg::*;
#(
    parameter int N_CORES = 4,
    parameter int DEPTH   = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    nonce_result_hub_if.slave  bus
);

    localparam int CW    = $clog2(N_CORES);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int RES_W = $bits(result_t);
    localparam int ENT_W = CW + RES_W;

    logic [N_CORES-1:0]    r_pend;
    logic [NONCE_W-1:0]    r_pend_nonce [N_CORES];
    logic [DIFY_W-1:0]     r_pend_dify  [N_CORES];
    logic [CW-1:0]         r_ptr;
    logic                  r_overflow;
    logic [DROP_W-1:0]     r_drop_count;
    logic                  r_busy;

    logic                  w_sel_vld;
    logic                  w_grant_vld;
    logic [CW-1:0]         w_grant_idx;
    logic [N_CORES-1:0]    w_grant_oh;
    logic [N_CORES-1:0]    w_drop;
    logic [DROP_INC_W-1:0] w_drop_num;
    result_t               w_push_res;
    result_t               w_head_res;
    logic [CW-1:0]         w_head_chan;
    logic [ENT_W-1:0]      w_head_word;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [CNT_W-1:0]      w_fifo_count;

    function automatic logic [CW-1:0] rr_idx(input logic [CW-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        return (sum >= N_CORES) ? CW'(sum - N_CORES) : CW'(sum);
    endfunction

    // Round-robin pick: scan from ptr downwards in priority so the nearest pending channel wins.
    always_comb begin
        w_sel_vld   = 1'b0;
        w_grant_idx = {CW{1'b0}};
        for (int i = N_CORES - 1; i >= 0; i--) begin
            w_sel_vld   = r_pend[rr_idx(r_ptr, i)] ? 1'b1 : w_sel_vld;
            w_grant_idx = r_pend[rr_idx(r_ptr, i)] ? rr_idx(r_ptr, i) : w_grant_idx;
        end
        w_grant_vld = w_sel_vld & ~w_fifo_full;
    end

    // Grant decode and collision detection; a strobe on the granted channel is a reload, not a drop.
    always_comb begin
        w_grant_oh = {N_CORES{1'b0}};
        w_drop     = {N_CORES{1'b0}};
        w_drop_num = {DROP_INC_W{1'b0}};
        for (int k = 0; k < N_CORES; k++) begin
            w_grant_oh[k] = w_grant_vld && (w_grant_idx == CW'(k));
            w_drop[k]     = bus.core_valid[k] & r_pend[k] & ~w_grant_oh[k];
            w_drop_num    = w_drop_num + DROP_INC_W'(w_drop[k]);
        end
    end

    // FIFO write payload taken from the granted pending slot.
    always_comb begin
        w_push_res.id_nonce  = r_pend_nonce[w_grant_idx];
        w_push_res.hash_dify = r_pend_dify[w_grant_idx];
    end

    // Pending slots and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pend <= {N_CORES{1'b0}};
            r_ptr  <= {CW{1'b0}};
            for (int k = 0; k < N_CORES; k++) begin
                r_pend_nonce[k] <= {NONCE_W{1'b0}};
                r_pend_dify[k]  <= {DIFY_W{1'b0}};
            end
        end else begin
            for (int k = 0; k < N_CORES; k++) begin
                if (bus.core_valid[k] && (!r_pend[k] || w_grant_oh[k])) begin
                    r_pend[k]       <= 1'b1;
                    r_pend_nonce[k] <= bus.core_id_nonce[k*NONCE_W +: NONCE_W];
                    r_pend_dify[k]  <= bus.core_hash_dify[k*DIFY_W +: DIFY_W];
                end else if (w_grant_oh[k]) begin
                    r_pend[k] <= 1'b0;
                end
            end
            if (w_grant_vld) begin
                r_ptr <= rr_idx(w_grant_idx, 32'sd1);
            end
        end
    end

    // Drop statistics (a same-cycle drop wins over clear) and registered busy summary.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_overflow   <= 1'b0;
            r_drop_count <= {DROP_W{1'b0}};
            r_busy       <= 1'b0;
        end else begin
            r_overflow   <= (r_overflow & ~bus.clr_overflow) | (|w_drop);
            r_drop_count <= sat_add_drop(bus.clr_overflow ? {DROP_W{1'b0}} : r_drop_count,
                                         w_drop_num);
            r_busy       <= (busy_mode_e'(bus.busy_mode) == BUSY_ANY) ? (|bus.core_busy)
                                                                      : (&bus.core_busy);
        end
    end

    result_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_result_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_grant_vld),
        .i_wdata ({w_grant_idx, w_push_res}),
        .i_pop   (bus.pop),
        .o_rdata (w_head_word),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    assign {w_head_chan, w_head_res} = w_head_word;

    assign bus.rd_valid     = ~w_fifo_empty;
    assign bus.rd_chan      = w_head_chan;
    assign bus.rd_id_nonce  = w_head_res.id_nonce;
    assign bus.rd_hash_dify = w_head_res.hash_dify;
    assign bus.fifo_count   = w_fifo_count;
    assign bus.irq          = (w_fifo_count != {CNT_W{1'b0}});
    assign bus.busy_out     = r_busy;
    assign bus.overflow     = r_overflow;
    assign bus.drop_count   = r_drop_count;

endmodule

// File: doc/nonce_result_hub.md
Name: nonce_result_hub

Overview:
- Parametrised successor to the fixed four-core result and busy plumbing.
- Collects nonce/difficulty results from N_CORES hashing cores without loss on simultaneous hits.
- Arbitrates results round-robin into a DEPTH-entry FIFO for the SPI side to drain, raises one aggregated irq, and produces a mode-selectable busy summary.
- Sits between the hyper-threading core array and the SPI slave, in the PLL clock domain.

Parameters:
- N_CORES, 4: number of core channels, 2..16.
- DEPTH, 8: result FIFO entries; power of two, 2..64.
- CW, derived (clog2(N_CORES)): width of the channel index. Localparam, not overridable.

Ports:
- clk  in  1  PLL core clock; all logic rising-edge.
- reset_n  in  1  synchronous active-low reset.
- core_valid  in  N_CORES  one-cycle result strobe per core.
- core_id_nonce  in  N_CORES*40  per-core {id,nonce}; channel k occupies bits [40k+39:40k].
- core_hash_dify  in  N_CORES*32  per-core hash difficulty; channel k occupies bits [32k+31:32k].
- core_busy  in  N_CORES  per-core busy level.
- busy_mode  in  1  0 = busy_out is AND of core_busy; 1 = busy_out is OR of core_busy.
- pop  in  1  consume the FIFO head.
- clr_overflow  in  1  clears overflow and drop_count.
- rd_valid  out  1  FIFO head valid (first-word fall-through).
- rd_chan  out  CW  channel index of the head entry.
- rd_id_nonce  out  40  head {id,nonce}.
- rd_hash_dify  out  32  head difficulty.
- fifo_count  out  clog2(DEPTH)+1  current occupancy.
- irq  out  1  high while fifo_count != 0.
- busy_out  out  1  registered busy summary.
- overflow  out  1  sticky flag: a result was dropped.
- drop_count  out  8  dropped results; saturates at 255.

Behaviour:
- Reset: on any clk edge with reset_n=0, clear:
  - all pending registers and the round-robin pointer (pointer = 0);
  - FIFO pointers, so fifo_count=0, rd_valid=0, irq=0;
  - rd_chan, rd_id_nonce, rd_hash_dify, busy_out, overflow, drop_count, all to 0.
  - Reset mid-operation discards all pending and queued results.
- Capture: each channel has a one-entry pending register.
  - core_valid[k] at edge t loads channel k's data and sets pend[k].
- Collision: core_valid[k] while pend[k]=1 and channel k is not granted that cycle.
  - The new result is dropped; the held result is kept.
  - overflow is set; drop_count increments (saturating).
- Same-cycle reload: core_valid[k] in the cycle channel k is granted → the new result loads into pending and pend[k] stays 1. This is not a drop.
- Multiple drops in one cycle: drop_count adds the number of drops, saturating at 255.
- Arbiter:
  - When the FIFO is not full, grant one pending channel per cycle.
  - Search order is ptr, ptr+1, … wrapping modulo N_CORES.
  - After granting channel g, ptr becomes (g+1) mod N_CORES.
  - No grant leaves ptr unchanged.
- Full: while fifo_count==DEPTH, no grant is issued, even if pop is asserted that cycle. Pending entries wait.
- Latency: core_valid at edge t → pending at t → granted and written at t+1 (if uncontended) → rd_valid=1 after edge t+1.
- FIFO:
  - First-word fall-through; rd_* show the head whenever rd_valid=1.
  - pop with rd_valid=0 is ignored.
  - Push and pop in the same cycle leave fifo_count unchanged.
  - Read and write pointers wrap modulo DEPTH.
- irq: derived from the registered count; no extra latency beyond the count register.
- busy_out: AND or OR of core_busy per busy_mode, registered; 1-cycle latency. A busy_mode change takes effect on the next edge.
- Clear precedence: clr_overflow clears overflow and drop_count. If a drop occurs in the same cycle, the result is overflow=1, drop_count=1.

Decomposition:
- Shared package/include holds:
  - NONCE_W=40, DIFY_W=32, DROP_W=8;
  - the FIFO entry layout {chan, id_nonce, hash_dify};
  - busy_mode encodings BUSY_ALL=0, BUSY_ANY=1.
- Sub-module result_fifo:
  - synchronous FWFT FIFO, parametrised on width and DEPTH;
  - provides full, empty and count.
- Arbiter, pending registers and counters live in the top of nonce_result_hub.

Test Plan:
- Single hit: core_valid[2] with id_nonce=40'h01_DEADBEEF, dify=32'h0000FFFF → rd_valid=1 two edges later with rd_chan=2 and matching data; irq=1; pop → fifo_count=0, irq=0.
- Simultaneous hits: core_valid=4'b1111 in one cycle → four entries read out in order 0,1,2,3; ptr ends at 0; no drops.
- Fairness: channels 0 and 3 pending every cycle with the FIFO draining → grants alternate 0,3,0,3.
- Full and collision:
  - DEPTH=8, FIFO filled, no pop.
  - Two more valids on channel 1 → the first is held pending; the second is dropped (overflow=1, drop_count=1).
  - After a pop, the held result enters the FIFO.
- Saturation and clear: 300 drops → drop_count=255; clr_overflow → overflow=0, drop_count=0.
- Busy and reset: core_busy=4'b0111 → busy_out=0 in mode 0, 1 in mode 1, each one edge after the mode is set; reset_n=0 with 3 queued entries → all outputs 0 on the next edge.
